// File: rtl/fetch_controller.sv
// fetch_controller
// ----------------
// Instruction fetch sequencer for the 16-bit core. Owns the fetch PC, drives
// the byte address into a combinational instruction ROM, buffers fetched
// {instruction, pc} pairs in a small prefetch queue and hands them to decode.
// Also handles branch redirects, halt detection ("B stop") and address faults.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   imem_addr      out  byte address to the ROM (always equals fetch_pc)
//   imem_instr     in   ROM data for imem_addr, same cycle
//   redirect_valid in   branch taken: flush queue, load fetch_pc
//   redirect_addr  in   branch target byte address
//   out_valid      out  queue head holds an instruction
//   out_instr      out  head instruction
//   out_pc         out  byte address of head instruction
//   out_ready      in   decode accepts the head this cycle
//   halted         out  halt instruction enqueued, fetching stopped
//   fault          out  bad fetch address seen, fetching stopped
//
// Handshake: a transfer to decode happens on a rising edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and
// once raised it stays high until the transfer completes, except that a
// redirect withdraws it (the queue is flushed and the transfer is dropped).
module fetch_controller #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          MEM_BYTES  = 264,
    parameter logic [15:0] HALT_INSTR = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        out_ready,
    output logic        halted,
    output logic        fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]    state;
    logic [15:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [15:0]   instr_q [DEPTH];
    logic [15:0]   pc_q    [DEPTH];

    logic full;
    logic pop;
    logic pc_bad;
    logic fetch;
    logic run_fault;

    // An address is unusable if misaligned or if the halfword read would run
    // past the end of the ROM. Compared in 32 bits so pc+2 cannot wrap.
    function automatic logic addr_bad(input logic [15:0] a);
        return (a[1:0] != 2'b00) || (({16'h0000, a} + 32'd2) > MEM_LIMIT);
    endfunction

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = instr_q[head];
    assign out_pc    = pc_q[head];
    assign halted    = (state == ST_HALT);
    assign fault     = (state == ST_FAULT);

    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign pc_bad    = addr_bad(fetch_pc);
    // A full queue may still accept a fetch when the head leaves this cycle.
    assign fetch     = (state == ST_RUN) && !redirect_valid && !pc_bad && (!full || pop);
    assign run_fault = (state == ST_RUN) && !redirect_valid && pc_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            // Storage is cleared so out_instr/out_pc are defined while empty.
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 16'h0000;
                pc_q[i]    <= 16'h0000;
            end
        end else if (redirect_valid) begin
            // Flush: any concurrent pop is dropped and nothing is fetched.
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= redirect_addr;
            state    <= addr_bad(redirect_addr) ? ST_FAULT : ST_RUN;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (fetch) begin
                instr_q[tail] <= imem_instr;
                pc_q[tail]    <= fetch_pc;
                tail          <= tail + PW'(1);
                // The halt instruction is still delivered; the PC parks on it.
                if (imem_instr == HALT_INSTR) begin
                    state <= ST_HALT;
                end else begin
                    fetch_pc <= fetch_pc + 16'd4;
                end
            end else if (run_fault) begin
                state <= ST_FAULT;
            end
            case ({fetch, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed phases (straight-line fetch under
// backpressure, halt, redirect with queued entries, faults, mid-run reset).
// Expected {pc, instr} pairs are queued by the driver; a negedge monitor pops
// and compares every completed transfer to decode.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];   // {pc, instr}
    logic [15:0] rom [66];

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .halted         (halted),
        .fault          (fault)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: word i holds 0x1000+i, word 65 (byte 0x104) holds B stop.
    initial begin
        for (int i = 0; i < 66; i++) rom[i] = 16'h1000 + 16'(i);
        rom[65] = 16'hE000;
    end
    assign imem_instr = (imem_addr < 16'd264) ? rom[imem_addr[9:2]] : 16'h0000;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] exp_instr(input logic [15:0] pc);
        return (pc == 16'h0104) ? 16'hE000 : (16'h1000 + {2'b00, pc[15:2]});
    endfunction

    // Expected delivery stream from 'start' up to and including the halt word.
    task automatic push_run(input logic [15:0] start);
        for (logic [15:0] pc = start; pc <= 16'h0104; pc += 16'd4)
            exp_q.push_back({pc, exp_instr(pc)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] addr, input logic expect_stream);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        exp_q.delete();
        if (expect_stream) push_run(addr);
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_halt_and_drain(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (halted) break;
        end
        check({tag, "_halted"}, {15'h0, halted}, 16'h0001);
        check({tag, "_halt_addr"}, imem_addr, 16'h0104);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        check({tag, "_drained_valid"}, {15'h0, out_valid}, 16'h0000);
        check({tag, "_exp_left"}, 16'(exp_q.size()), 16'h0000);
        check({tag, "_addr_parked"}, imem_addr, 16'h0104);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && !redirect_valid && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_pc", out_pc, 16'hFFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e[31:16]);
                check("out_instr", out_instr, e[15:0]);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        out_ready      = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_valid",  {15'h0, out_valid}, 16'h0000);
        check("rst_instr",  out_instr, 16'h0000);
        check("rst_pc",     out_pc, 16'h0000);
        check("rst_halted", {15'h0, halted}, 16'h0000);
        check("rst_fault",  {15'h0, fault}, 16'h0000);
        check("rst_addr",   imem_addr, 16'h0000);

        // Backpressure: four fetches fill the queue, PC parks at 0x10.
        cyc();
        reset = 1'b0;
        push_run(16'h0000);
        @(negedge clk);
        check("c0_valid", {15'h0, out_valid}, 16'h0000);
        repeat (6) cyc();
        @(negedge clk);
        check("full_valid", {15'h0, out_valid}, 16'h0001);
        check("full_pc",    out_pc, 16'h0000);
        check("full_addr",  imem_addr, 16'h0010);
        cyc();
        out_ready = 1'b1;
        // Drain with no gap; the fetch PC keeps leading by 4 queued words.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("nogap_valid", {15'h0, out_valid}, 16'h0001);
            check("nogap_addr",  imem_addr, 16'h0010 + 16'(4 * k));
            cyc();
        end
        wait_halt_and_drain("run1");

        // Leave halt via redirect to 0, then build up three entries.
        cyc();
        out_ready = 1'b0;
        redirect(16'h0000, 1'b1);
        @(negedge clk);
        check("unhalt", {15'h0, halted}, 16'h0000);
        check("unhalt_valid", {15'h0, out_valid}, 16'h0000);
        repeat (3) cyc();

        // Redirect with three queued entries and a concurrent pop.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0068;
        exp_q.delete();
        push_run(16'h0068);
        @(negedge clk);
        check("pre_redir_pc", out_pc, 16'h0000);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_bubble", {15'h0, out_valid}, 16'h0000);
        cyc();
        @(negedge clk);
        check("redir_valid", {15'h0, out_valid}, 16'h0001);
        check("redir_pc",    out_pc, 16'h0068);
        check("redir_instr", out_instr, 16'h101A);

        // Misaligned redirect target.
        cyc();
        redirect(16'h0042, 1'b0);
        @(negedge clk);
        check("mis_fault", {15'h0, fault}, 16'h0001);
        check("mis_valid", {15'h0, out_valid}, 16'h0000);
        check("mis_addr",  imem_addr, 16'h0042);
        repeat (2) cyc();
        @(negedge clk);
        check("mis_still_empty", {15'h0, out_valid}, 16'h0000);
        check("mis_still_fault", {15'h0, fault}, 16'h0001);

        // Recover near the top of the ROM, run into halt.
        cyc();
        redirect(16'h0100, 1'b1);
        @(negedge clk);
        check("recover_fault", {15'h0, fault}, 16'h0000);
        wait_halt_and_drain("run2");

        // Out-of-range target: 0x108 + 2 > 264.
        cyc();
        redirect(16'h0108, 1'b0);
        @(negedge clk);
        check("oor_fault",  {15'h0, fault}, 16'h0001);
        check("oor_halted", {15'h0, halted}, 16'h0000);
        check("oor_valid",  {15'h0, out_valid}, 16'h0000);

        // Mid-run reset.
        cyc();
        redirect(16'h0000, 1'b1);
        repeat (5) cyc();
        reset = 1'b1;
        exp_q.delete();
        cyc();
        @(negedge clk);
        check("mrst_valid", {15'h0, out_valid}, 16'h0000);
        check("mrst_pc",    out_pc, 16'h0000);
        check("mrst_instr", out_instr, 16'h0000);
        check("mrst_fault", {15'h0, fault}, 16'h0000);
        check("mrst_addr",  imem_addr, 16'h0000);
        cyc();
        reset = 1'b0;
        push_run(16'h0000);
        wait_halt_and_drain("run3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Instruction fetch sequencer for the 16-bit core. It owns the fetch PC and drives the byte address into the combinational instruction ROM (word index = address/4, so the PC advances by 4 per instruction). It buffers fetched instructions with their PCs in a small prefetch queue and delivers them to decode over a valid/ready handshake. It also handles branch redirects, halt detection and address faults.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, 2..16.
RESET_PC, 16'h0000, fetch PC after reset.
MEM_BYTES, 264, byte size of ROM address space; fetch at or beyond this faults.
HALT_INSTR, 16'hE000, encoding of "B stop"; fetching it halts the fetcher.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
imem_addr  out  16  byte address to instruction ROM; combinational copy of fetch_pc.
imem_instr  in  16  ROM read data for imem_addr, same cycle.
redirect_valid  in  1  branch taken; load fetch PC from redirect_addr.
redirect_addr  in  16  branch target byte address.
out_valid  out  1  queue head holds a valid instruction.
out_instr  out  16  head instruction.
out_pc  out  16  byte address of head instruction.
out_ready  in  1  decode accepts head this cycle.
halted  out  1  HALT_INSTR has been enqueued and fetching has stopped.
fault  out  1  misaligned or out-of-range fetch address; fetching has stopped.

Behaviour:
- Reset (sync, active-high, overrides all inputs): fetch_pc=RESET_PC; queue empty; state RUN; out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0; imem_addr=RESET_PC.
- States: RUN, HALT, FAULT. halted=(state==HALT), fault=(state==FAULT), both registered.
- imem_addr = fetch_pc at all times, including in HALT and FAULT.
- Fetch condition (RUN only): not redirect_valid, and queue not full or a pop occurs this cycle. On fetch, {imem_instr, fetch_pc} is written to the tail at the clock edge.
- After a fetch: if imem_instr==HALT_INSTR, go to HALT and leave fetch_pc unchanged. Otherwise fetch_pc+=4.
- Range check before fetching in RUN: if fetch_pc+2 > MEM_BYTES or fetch_pc[1:0]!=0, do not enqueue and go to FAULT.
- Pop: out_valid && out_ready. The head advances at the edge.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1. With out_ready held high, throughput is 1 instruction per cycle.
- out_instr/out_pc come directly from queue storage at the head pointer. When out_valid=0 their values are don't-care but must not be X after reset.
- Redirect (any state, highest priority after reset):
  - Queue flushed (count=0) at the edge.
  - Any concurrent pop is discarded.
  - No fetch in the redirect cycle.
  - fetch_pc=redirect_addr.
  - State: RUN, or FAULT if redirect_addr[1:0]!=0 or redirect_addr+2 > MEM_BYTES.
  - out_valid=0 in the next cycle. The first target instruction appears 2 cycles after the redirect cycle.
- Full queue with a simultaneous pop: fetch proceeds and count stays the same.
- Empty queue: out_valid=0 and out_ready is ignored.
- In HALT or FAULT: the queue continues draining normally. Only a redirect or reset leaves these states.
- Pointers wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- PC arithmetic is 16-bit unsigned. Wrap past 16'hFFFC is unreachable because the range check catches it first.

Test Plan:
- Straight-line: release reset, out_ready=1 -> first out_valid in cycle 1 with out_pc=0x0000, out_instr=ROM[0]; then out_pc 0x0004, 0x0008, ... one per cycle; imem_addr leads out_pc by 4.
- Backpressure: out_ready=0 from reset -> after 4 fetches queue full, imem_addr holds 0x0010, out_pc holds 0x0000. Raise out_ready -> pcs 0x0000..0x000C drain in order with no gap, then 0x0010 follows.
- Redirect with 3 entries queued and out_ready=1 same cycle, redirect_addr=0x0068 -> next cycle out_valid=0. The cycle after: out_valid=1, out_pc=0x0068, out_instr=ROM[26]. The popped entry is never counted as consumed.
- Halt: run to 0x0104 (ROM[65]=16'hE000) -> entry enqueued, halted=1 the next cycle, imem_addr stays 0x0104, queue drains to out_valid=0. Then redirect_addr=0x0000 -> halted=0 and fetching resumes from 0x0000.
- Fault: redirect_addr=0x0042 -> fault=1 next cycle, no enqueue, out_valid=0. Separately, redirect_addr=0x0108 -> fault=1. Reset mid-run -> all outputs 0, fetch restarts at 0x0000.
